// File: rtl/dbg_frame_pkg.sv
// Shared constants and FSM state type for the debug frame generator.
// Optional checksum state exists only when DBG_FRAME_GEN_CHKSUM_EN is defined.
package dbg_frame_pkg;

    localparam logic [7:0]  CMD_WRITE = 8'h10;
    localparam logic [7:0]  CMD_READ  = 8'h11;
    localparam int unsigned HDR_BYTES = 6;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StFetch,
        StWait,
        StData,
`ifdef DBG_FRAME_GEN_CHKSUM_EN
        StChk,
`endif
        StDone
    } state_e;

endpackage

// File: rtl/dbg_frame_gen_if.sv
// Memory read port and byte stream of the debug frame generator.
// master = frame generator side, slave = memory / downstream FIFO side.
interface dbg_frame_gen_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 10
);
    logic              rd_en;
    logic [MEM_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_accept;

    modport master (
        output rd_en, rd_addr, tx_data, tx_valid,
        input  rd_data, tx_accept
    );

    modport slave (
        input  rd_en, rd_addr, tx_data, tx_valid,
        output rd_data, tx_accept
    );
endinterface

// File: rtl/dbg_word_ser.sv
// Serialises one memory word into bytes, most-significant byte first, under a
// valid/accept handshake. nbytes_i limits how many leading bytes are emitted so
// a short final word drops its low-order bytes.
module dbg_word_ser #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W / 8 + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [CNT_W-1:0]  nbytes_i,
    input  logic              accept_i,
    output logic [7:0]        data_o,
    output logic              valid_o,
    output logic              last_o
);
    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;

    // Load a new word, or shift one byte out per accepted transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            cnt_q  <= nbytes_i;
        end else if (valid_o && accept_i) begin
            word_q <= word_q << 8;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

    assign data_o  = word_q[DATA_W-1 -: 8];
    assign valid_o = (cnt_q != '0);
    assign last_o  = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/dbg_frame_gen.sv
// Debug frame generator: emits cmd, len and 4 address bytes, then for write
// frames a payload of len bytes read word-by-word from memory.
// Define DBG_FRAME_GEN_CHKSUM_EN to append an XOR checksum byte to each frame.
module dbg_frame_gen
    import dbg_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cmd_rd_i,
    input  logic [31:0]       addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [MEM_AW-1:0] base_i,
    output logic              busy_o,
    output logic              done_o,
    dbg_frame_gen_if.master   bus
);
    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned CNT_W    = $clog2(BYTES + 1);
    localparam logic [2:0]  HDR_LAST = 3'(HDR_BYTES - 1);

    state_e            state_q;
    logic [39:0]       hdr_q;       // header bytes still to be presented after the current one
    logic [2:0]        hdr_left_q;  // header bytes remaining after the one on the bus
    logic [LEN_W-1:0]  rem_q;       // payload bytes not yet handed to the serialiser
    logic [MEM_AW-1:0] rd_addr_q;
    logic              rd_en_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;

    logic              ser_load;
    logic [CNT_W-1:0]  ser_nbytes;
    logic [7:0]        ser_data;
    logic              ser_valid;
    logic              ser_last;
    logic [7:0]        tx_data;

`ifdef DBG_FRAME_GEN_CHKSUM_EN
    logic [7:0]        chk_q;
    logic [7:0]        chk_next;
    assign chk_next = chk_q ^ tx_data;
`endif

    // Bytes taken from the next word: a full word, or whatever is left of len.
    always_comb begin
        ser_nbytes = CNT_W'(BYTES);
        if (32'(rem_q) < BYTES) begin
            ser_nbytes = CNT_W'(rem_q);
        end
    end

    assign ser_load = (state_q == StWait);

    dbg_word_ser #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_ser (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ser_load),
        .word_i   (bus.rd_data),
        .nbytes_i (ser_nbytes),
        .accept_i (bus.tx_accept),
        .data_o   (ser_data),
        .valid_o  (ser_valid),
        .last_o   (ser_last)
    );

    // Frame sequencing FSM; all handshake outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            hdr_q      <= '0;
            hdr_left_q <= '0;
            rem_q      <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DBG_FRAME_GEN_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        tx_data_q  <= cmd_rd_i ? CMD_READ : CMD_WRITE;
                        tx_valid_q <= 1'b1;
                        hdr_q      <= {8'(len_i), addr_i};
                        hdr_left_q <= HDR_LAST;
                        // A read frame carries no payload, same path as len = 0.
                        rem_q      <= cmd_rd_i ? '0 : len_i;
                        rd_addr_q  <= base_i;
                        busy_q     <= 1'b1;
`ifdef DBG_FRAME_GEN_CHKSUM_EN
                        chk_q      <= '0;
`endif
                        state_q    <= StHdr;
                    end
                end
                StHdr: begin
                    if (bus.tx_accept) begin
`ifdef DBG_FRAME_GEN_CHKSUM_EN
                        chk_q <= chk_next;
`endif
                        if (hdr_left_q == '0) begin
                            tx_valid_q <= 1'b0;
                            if (rem_q != '0) begin
                                rd_en_q <= 1'b1;
                                state_q <= StFetch;
                            end else begin
`ifdef DBG_FRAME_GEN_CHKSUM_EN
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= chk_next;
                                state_q    <= StChk;
`else
                                done_q     <= 1'b1;
                                state_q    <= StDone;
`endif
                            end
                        end else begin
                            tx_data_q  <= hdr_q[39:32];
                            hdr_q      <= hdr_q << 8;
                            hdr_left_q <= hdr_left_q - 3'd1;
                        end
                    end
                end
                StFetch: begin
                    rd_en_q <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Word is on rd_data now and is captured by the serialiser.
                    rd_addr_q <= rd_addr_q + MEM_AW'(1);
                    rem_q     <= rem_q - LEN_W'(ser_nbytes);
                    state_q   <= StData;
                end
                StData: begin
                    if (ser_valid && bus.tx_accept) begin
`ifdef DBG_FRAME_GEN_CHKSUM_EN
                        chk_q <= chk_next;
`endif
                        if (ser_last) begin
                            if (rem_q != '0) begin
                                rd_en_q <= 1'b1;
                                state_q <= StFetch;
                            end else begin
`ifdef DBG_FRAME_GEN_CHKSUM_EN
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= chk_next;
                                state_q    <= StChk;
`else
                                done_q     <= 1'b1;
                                state_q    <= StDone;
`endif
                            end
                        end
                    end
                end
`ifdef DBG_FRAME_GEN_CHKSUM_EN
                StChk: begin
                    if (bus.tx_accept) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end
                end
`endif
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_data      = ser_valid ? ser_data : tx_data_q;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid_q | ser_valid;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_dbg_frame_gen.sv
// Directed bench for dbg_frame_gen with a word memory model and byte monitor.
module tb_dbg_frame_gen;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned MEM_AW = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cmd_rd = 1'b0;
    logic [31:0]       addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic [MEM_AW-1:0] base = '0;
    logic              busy;
    logic              done;

    dbg_frame_gen_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus ();

    dbg_frame_gen #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .MEM_AW (MEM_AW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .cmd_rd_i (cmd_rd),
        .addr_i   (addr),
        .len_i    (len),
        .base_i   (base),
        .busy_o   (busy),
        .done_o   (done),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Memory: word appears on rd_data the cycle after rd_en.
    logic [DATA_W-1:0] mem [2**MEM_AW];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Monitor at the falling edge: record transfers, fetch addresses, done pulses
    // and any change of a stalled byte.
    logic [7:0]        got_q [$];
    logic [MEM_AW-1:0] rda_q [$];
    int                n_done = 0;
    int                stall_err = 0;
    logic              stalled = 1'b0;
    logic [7:0]        stall_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && (!bus.tx_valid || bus.tx_data !== stall_data)) stall_err++;
            stalled    = bus.tx_valid && !bus.tx_accept;
            stall_data = bus.tx_data;
            if (bus.tx_valid && bus.tx_accept) got_q.push_back(bus.tx_data);
            if (bus.rd_en) rda_q.push_back(bus.rd_addr);
            if (done) n_done++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then scramble the captured inputs.
    task automatic start_frame(input logic rd, input logic [31:0] a,
                               input logic [LEN_W-1:0] l, input logic [MEM_AW-1:0] b);
        got_q.delete();
        rda_q.delete();
        n_done    = 0;
        stall_err = 0;
        cmd_rd = rd;
        addr   = a;
        len    = l;
        base   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cmd_rd = ~rd;
        addr   = ~a;
        len    = ~l;
        base   = ~b;
    endtask

    // Run until done, optionally stalling on payload byte 3 and poking start
    // while busy and in the done cycle.
    task automatic run_to_done(input bit bp, input bit poke, input string tag);
        int stall = 0;
        bit seen  = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            seen = done;
            bus.tx_accept = !(bp && got_q.size() == 9 && stall < 5);
            if (!bus.tx_accept) stall++;
            start = poke && (c == 3 || done);
            tick();
            start = 1'b0;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        bus.tx_accept = 1'b1;
        tick();
        tick();
        tick();
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_valid_after"}, 64'(bus.tx_valid), 64'd0);
        check({tag, "_done_cnt"}, 64'(n_done), 64'd1);
    endtask

    task automatic cmp_bytes(input string tag, input logic [7:0] exp_in [$], input logic [7:0] chk);
        logic [7:0] exp [$];
        logic [7:0] g;
        exp = exp_in;
`ifdef DBG_FRAME_GEN_CHKSUM_EN
        exp.push_back(chk);
`else
        if (chk === 8'hxx) exp.delete();
`endif
        check({tag, "_nbytes"}, 64'(got_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 64'(g), 64'(exp[i]));
        end
    endtask

    logic [7:0] e [$];

    initial begin
        for (int i = 0; i < 2**MEM_AW; i++) mem[i] = 32'h5A5A0000 | 32'(i);
        mem[0]    = 32'h00112233;
        mem[1]    = 32'h44556677;
        mem[2]    = 32'h8899AABB;
        mem[3]    = 32'hCCDDEEFF;
        mem[1023] = 32'hDEADBEEF;
        bus.tx_accept = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_rd_en", 64'(bus.rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        rst = 1'b0;
        tick();

        // Write frame, len 13, truncated last word
        start_frame(1'b0, 32'h0, 8'd13, 10'd0);
        check("w13_valid_first", 64'(bus.tx_valid), 64'd1);
        check("w13_busy_first", 64'(busy), 64'd1);
        check("w13_cmd_first", 64'(bus.tx_data), 64'h10);
        run_to_done(1'b0, 1'b1, "w13");
        e = '{8'h10, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33,
              8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        cmp_bytes("w13", e, 8'hD1);
        check("w13_rd_pulses", 64'(rda_q.size()), 64'd4);
        if (rda_q.size() == 4) check("w13_rd_addr3", 64'(rda_q[3]), 64'd3);

        // Read frame: header only
        start_frame(1'b1, 32'h00000001, 8'd13, 10'd5);
        run_to_done(1'b0, 1'b0, "rd");
        e = '{8'h11, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h01};
        cmp_bytes("rd", e, 8'h1D);
        check("rd_rd_pulses", 64'(rda_q.size()), 64'd0);

        // Backpressure on payload byte 3
        start_frame(1'b0, 32'h0, 8'd13, 10'd0);
        run_to_done(1'b1, 1'b0, "bp");
        e = '{8'h10, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33,
              8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        cmp_bytes("bp", e, 8'hD1);
        check("bp_stable", 64'(stall_err), 64'd0);

        // Write frame with len 0
        start_frame(1'b0, 32'hA5000003, 8'd0, 10'd7);
        run_to_done(1'b0, 1'b0, "len0");
        e = '{8'h10, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h03};
        cmp_bytes("len0", e, 8'hB6);
        check("len0_rd_pulses", 64'(rda_q.size()), 64'd0);

        // Address wrap at top of memory
        start_frame(1'b0, 32'h12345678, 8'd8, 10'd1023);
        run_to_done(1'b0, 1'b0, "wrap");
        e = '{8'h10, 8'h08, 8'h12, 8'h34, 8'h56, 8'h78,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h11, 8'h22, 8'h33};
        cmp_bytes("wrap", e, 8'h32);
        check("wrap_rd_pulses", 64'(rda_q.size()), 64'd2);
        if (rda_q.size() == 2) begin
            check("wrap_addr0", 64'(rda_q[0]), 64'd1023);
            check("wrap_addr1", 64'(rda_q[1]), 64'd0);
        end

        // Reset mid-payload, then a fresh frame
        start_frame(1'b0, 32'h0, 8'd13, 10'd0);
        for (int c = 0; c < 100 && got_q.size() < 8; c++) tick();
        check("mid_reached", 64'(got_q.size() >= 8), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(bus.tx_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rd_en", 64'(bus.rd_en), 64'd0);
        check("mid_rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("mid_rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        check("mid_no_resume", 64'(bus.tx_valid), 64'd0);
        start_frame(1'b1, 32'hCAFEF00D, 8'd5, 10'd0);
        run_to_done(1'b0, 1'b0, "fresh");
        e = '{8'h11, 8'h05, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        cmp_bytes("fresh", e, 8'hDD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
